// File: rtl/input_and_mar_pkg.sv
// Shared width and type definitions for the SAP-1 input / memory-address-register stage.
package input_and_mar_pkg;

  localparam int ADDR_W = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  // Mode-select encoding on run_or_prog.
  typedef enum logic {
    MODE_PROG = 1'b0,
    MODE_RUN  = 1'b1
  } mode_e;

endpackage : input_and_mar_pkg

// File: rtl/input_and_mar_addr_mux_157.sv
// Quad 2:1 selector modelled on the 74LS157: Y = A when select is low, B when high,
// forced to zero while the strobe is high.
module input_and_mar_addr_mux_157
  import input_and_mar_pkg::*;
(
  input  logic  i_sel,
  input  logic  i_g_n,
  input  addr_t i_a,
  input  addr_t i_b,
  output addr_t o_y
);

  always_comb begin
    o_y = '0;
    if (!i_g_n) begin
      o_y = i_sel ? i_b : i_a;
    end
  end

endmodule : input_and_mar_addr_mux_157

// File: rtl/input_and_mar_mar_reg_173.sv
// 4-bit register modelled on the 74LS173: synchronous clear, two active-low load gates,
// and two output enables.
module input_and_mar_mar_reg_173
  import input_and_mar_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_clr_n,
  input  logic  i_g1_n,
  input  logic  i_g2_n,
  input  logic  i_m,
  input  logic  i_n,
  input  addr_t i_d,
  output addr_t o_q
);

  addr_t r_q;
  logic  w_load;

  assign w_load = ~i_g1_n & ~i_g2_n;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_q <= '0;
    end else if (w_load) begin
      r_q <= i_d;
    end
  end

  // The real part floats its outputs when M or N is high; on-chip there is no tri-state bus, so drive zero.
  assign o_q = (i_m | i_n) ? '0 : r_q;

endmodule : input_and_mar_mar_reg_173

// File: rtl/input_and_mar.sv
// SAP-1 input and MAR stage: latches the W-bus low nibble into the MAR and selects the RAM
// address from the MAR (run) or the front-panel switches (program).
module input_and_mar
  import input_and_mar_pkg::*;
(
  input  logic  CLK,
  input  logic  CLR_bar,
  input  logic  L_M_bar,
  input  addr_t bus_address,
  input  addr_t programmer_address,
  input  logic  run_or_prog,
  output addr_t address
);

  addr_t w_mar;
  mode_e w_mode;

  assign w_mode = mode_e'(run_or_prog);

  // Both load gates share L_M_bar; output enables are tied low so the MAR always drives.
  input_and_mar_mar_reg_173 u_mar (
    .i_clk   (CLK),
    .i_clr_n (CLR_bar),
    .i_g1_n  (L_M_bar),
    .i_g2_n  (L_M_bar),
    .i_m     (1'b0),
    .i_n     (1'b0),
    .i_d     (bus_address),
    .o_q     (w_mar)
  );

  input_and_mar_addr_mux_157 u_mux (
    .i_sel (w_mode == MODE_RUN),
    .i_g_n (1'b0),
    .i_a   (programmer_address),
    .i_b   (w_mar),
    .o_y   (address)
  );

endmodule : input_and_mar

// File: tb/tb_input_and_mar.sv
// Scoreboard bench for input_and_mar: stimulus queues hand-computed addresses, a monitor
// compares them against the DUT whenever an observation strobe fires.
module tb_input_and_mar;
  import input_and_mar_pkg::*;

  logic  CLK;
  logic  CLR_bar;
  logic  L_M_bar;
  addr_t bus_address;
  addr_t programmer_address;
  logic  run_or_prog;
  addr_t address;

  input_and_mar dut (
    .CLK                (CLK),
    .CLR_bar            (CLR_bar),
    .L_M_bar            (L_M_bar),
    .bus_address        (bus_address),
    .programmer_address (programmer_address),
    .run_or_prog        (run_or_prog),
    .address            (address)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  addr_t exp_q[$];
  string name_q[$];
  logic  r_obs;
  int    n_cmp;
  int    n_err;

  initial begin
    r_obs = 1'b0;
    n_cmp = 0;
    n_err = 0;
  end

  // Monitor: pops one expectation per observation strobe.
  always @(posedge r_obs) begin
    addr_t exp_v;
    string nm;
    if (exp_q.size() == 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL unexpected_observation: address=%h with empty scoreboard", address);
    end else begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      n_cmp = n_cmp + 1;
      if (address !== exp_v) begin
        n_err = n_err + 1;
        $display("FAIL %s: address got %h expected %h", nm, address, exp_v);
      end
    end
  end

  task automatic check(input string nm, input addr_t exp_v);
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
    r_obs = 1'b1;
    #1;
    r_obs = 1'b0;
  endtask

  // Advance past a rising edge; leaves time at edge+2 so outputs have settled.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    CLR_bar            = 1'b0;
    L_M_bar            = 1'b1;
    run_or_prog        = 1'b1;
    bus_address        = 4'h0;
    programmer_address = 4'h0;

    tick();
    check("reset_run", 4'h0);
    run_or_prog        = 1'b0;
    programmer_address = 4'hA;
    #1;
    check("reset_prog", 4'hA);

    // Load in run mode.
    CLR_bar            = 1'b1;
    L_M_bar            = 1'b0;
    run_or_prog        = 1'b1;
    bus_address        = 4'h3;
    programmer_address = 4'h7;
    tick();
    check("load_run", 4'h3);

    run_or_prog = 1'b0;
    #1;
    check("prog_mode_comb", 4'h7);

    // Hold with load disabled.
    L_M_bar     = 1'b1;
    bus_address = 4'hC;
    tick();
    tick();
    run_or_prog = 1'b1;
    #1;
    check("hold", 4'h3);

    L_M_bar = 1'b0;
    tick();
    check("reload", 4'hC);

    // Reset beats load, then load takes effect once reset lifts.
    CLR_bar     = 1'b0;
    bus_address = 4'h9;
    tick();
    check("reset_priority", 4'h0);
    CLR_bar = 1'b1;
    tick();
    check("load_after_reset", 4'h9);

    // Only the value present at the edge is captured.
    bus_address = 4'h2;
    #1;
    bus_address = 4'h6;
    tick();
    check("edge_capture", 4'h6);

    L_M_bar     = 1'b1;
    bus_address = 4'h1;
    tick();
    check("no_load_bus_change", 4'h6);

    // Program-mode isolation: switches drive the address while the MAR still loads.
    run_or_prog = 1'b0;
    L_M_bar     = 1'b0;
    bus_address = 4'h5;
    for (int p = 0; p < 16; p++) begin
      programmer_address = addr_t'(p);
      tick();
      check($sformatf("prog_sweep_%0d", p), addr_t'(p));
    end
    run_or_prog = 1'b1;
    #1;
    check("prog_isolation_run", 4'h5);

    // Reset in program mode still clears the MAR.
    run_or_prog        = 1'b0;
    programmer_address = 4'hE;
    CLR_bar            = 1'b0;
    tick();
    check("reset_in_prog", 4'hE);
    run_or_prog = 1'b1;
    #1;
    check("reset_in_prog_run", 4'h0);

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_input_and_mar
